video_timing_gen: RTL

//  Raster timing generator for the HDMI output path. It consumes the divided

---
 rtl/video_timing_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: counts pixel-clock rising edges (sampled on inputclock)
// into h/v positions and emits registered sync, data-enable, coordinates and strobes.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12,
  parameter int FRM_W     = 16
) (
  input  logic             inputclock,
  input  logic             clock_reset_n,
  input  logic             pixel_clock_in,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             pix_q;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [FRM_W-1:0] fc_q, fc_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic             tick, wrap, upd;

  function automatic logic in_range(input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  // pix_q resets high so a level already high at reset release is not an edge
  assign tick = pixel_clock_in & ~pix_q;
  assign wrap = (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    upd     = 1'b0;
    h_nxt   = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
    if (h_q != H_LAST) v_nxt = v_q;
    else               v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = '0;
          fs_d    = 1'b1;
          ls_d    = 1'b1;
          fc_d    = fc_q + FRM_W'(1);
          upd     = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          if (wrap && !enable) begin
            // frame_cnt keeps counting started frames across idle periods
            state_d = IDLE;
            h_d     = '0;
            v_d     = '0;
            de_d    = 1'b0;
            hs_d    = ~HSYNC_POL;
            vs_d    = ~VSYNC_POL;
          end else begin
            h_d  = h_nxt;
            v_d  = v_nxt;
            ls_d = (h_nxt == '0);
            upd  = 1'b1;
            if (wrap) begin
              fs_d = 1'b1;
              fc_d = fc_q + FRM_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (upd) begin
      de_d = (h_d < H_ACT) && (v_d < V_ACT);
      hs_d = in_range(h_d, HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
      vs_d = in_range(v_d, VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  always_ff @(posedge inputclock or negedge clock_reset_n) begin
    if (!clock_reset_n) begin
      state_q <= IDLE;
      pix_q   <= 1'b1;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pixel_clock_in;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule
